// File: rtl/fabric_reset_ctrl.sv
// Fabric reset sequencer: holds GL0 user logic in reset until CCC lock is stable,
// the MSS is ready (only with FABRIC_RST_MSS_WAIT_EN defined) and a hold time has elapsed.
module fabric_reset_ctrl #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16
) (
  input  logic       GL0,
  input  logic       RESET,
  input  logic       LOCK,
  input  logic       MSS_READY,
  input  logic       SW_RESET_REQ,
  output logic       FABRIC_RESET_N,
  output logic       RUN_START,
  output logic [7:0] LOCK_LOST_CNT,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    ST_RST       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_WAIT_MSS  = 3'd3,
    ST_HOLD      = 3'd4,
    ST_RUN       = 3'd5
  } state_t;

  localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(RESET_HOLD_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic        r_lock_meta;
  logic        r_lock_s;
  logic        r_lock_d;
  logic        w_lock_fall;
  logic        w_mss_s;
  logic [7:0]  r_lost_cnt;
  logic        r_run_start;

  // Lock synchronizer plus one delayed copy for fall detection
  always_ff @(posedge GL0) begin
    if (RESET) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_lock_d    <= 1'b0;
    end else begin
      r_lock_meta <= LOCK;
      r_lock_s    <= r_lock_meta;
      r_lock_d    <= r_lock_s;
    end
  end

`ifdef FABRIC_RST_MSS_WAIT_EN
  logic r_mss_meta;
  logic r_mss_s;

  // MSS ready synchronizer
  always_ff @(posedge GL0) begin
    if (RESET) begin
      r_mss_meta <= 1'b0;
      r_mss_s    <= 1'b0;
    end else begin
      r_mss_meta <= MSS_READY;
      r_mss_s    <= r_mss_meta;
    end
  end

  assign w_mss_s = r_mss_s;
`else
  logic w_unused_mss;

  assign w_unused_mss = MSS_READY;
  assign w_mss_s      = 1'b1;
`endif

  assign w_lock_fall = r_lock_d & ~r_lock_s;

  // Next-state and dwell counter
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RST: begin
        w_state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (r_lock_s) begin
          w_cnt_nxt   = 16'd0;
          w_state_nxt = ST_STABLE;
        end else begin
          w_state_nxt = ST_WAIT_LOCK;
        end
      end
      ST_STABLE: begin
        if (!r_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (r_cnt == STABLE_LAST) begin
          w_cnt_nxt   = 16'd0;
`ifdef FABRIC_RST_MSS_WAIT_EN
          w_state_nxt = ST_WAIT_MSS;
`else
          w_state_nxt = ST_HOLD;
`endif
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      ST_WAIT_MSS: begin
        if (!r_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (w_mss_s) begin
          w_cnt_nxt   = 16'd0;
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_WAIT_MSS;
        end
      end
      ST_HOLD: begin
        if (!r_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (r_cnt == HOLD_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      ST_RUN: begin
        // Lock loss takes priority over a software request
        if (!r_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (SW_RESET_REQ) begin
          w_cnt_nxt   = 16'd0;
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RST;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  // State, counter and registered status outputs
  always_ff @(posedge GL0) begin
    if (RESET) begin
      r_state     <= ST_RST;
      r_cnt       <= 16'd0;
      r_run_start <= 1'b0;
      r_lost_cnt  <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_run_start <= (w_state_nxt == ST_RUN) && (r_state != ST_RUN);
      if (w_lock_fall && (r_lost_cnt != 8'hFF)) begin
        r_lost_cnt <= r_lost_cnt + 8'd1;
      end else begin
        r_lost_cnt <= r_lost_cnt;
      end
    end
  end

  assign FABRIC_RESET_N = (r_state == ST_RUN);
  assign RUN_START      = r_run_start;
  assign LOCK_LOST_CNT  = r_lost_cnt;
  assign STATE          = r_state;

endmodule

// File: tb/tb_fabric_reset_ctrl.sv
// Scoreboard bench for fabric_reset_ctrl (LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4);
// expectations adapt to whether FABRIC_RST_MSS_WAIT_EN is defined.
module tb_fabric_reset_ctrl;

  localparam int LSC = 8;
  localparam int RHC = 4;
`ifdef FABRIC_RST_MSS_WAIT_EN
  localparam int MSS_EXTRA = 1;
  localparam logic [2:0] ST_AFTER_STABLE = 3'd3;
`else
  localparam int MSS_EXTRA = 0;
  localparam logic [2:0] ST_AFTER_STABLE = 3'd4;
`endif

  logic       GL0 = 1'b0;
  logic       RESET;
  logic       LOCK;
  logic       MSS_READY;
  logic       SW_RESET_REQ;
  logic       FABRIC_RESET_N;
  logic       RUN_START;
  logic [7:0] LOCK_LOST_CNT;
  logic [2:0] STATE;

  typedef struct {
    int         cyc;
    string      tag;
    logic [2:0] st;
    logic       rn;
    logic       rs;
    logic [7:0] lc;
  } exp_t;

  exp_t q[$];
  int   ecnt    = 0;
  int   n_total = 0;
  int   n_bad   = 0;

  fabric_reset_ctrl #(
    .LOCK_STABLE_CYCLES(LSC),
    .RESET_HOLD_CYCLES (RHC)
  ) dut (
    .GL0           (GL0),
    .RESET         (RESET),
    .LOCK          (LOCK),
    .MSS_READY     (MSS_READY),
    .SW_RESET_REQ  (SW_RESET_REQ),
    .FABRIC_RESET_N(FABRIC_RESET_N),
    .RUN_START     (RUN_START),
    .LOCK_LOST_CNT (LOCK_LOST_CNT),
    .STATE         (STATE)
  );

  always #5 GL0 = ~GL0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, expv, ecnt);
    end
  endtask

  task automatic push_exp(input int cyc, input string tag, input logic [2:0] st,
                          input logic rn, input logic rs, input logic [7:0] lc);
    exp_t e;
    e.cyc = cyc;
    e.tag = tag;
    e.st  = st;
    e.rn  = rn;
    e.rs  = rs;
    e.lc  = lc;
    q.push_back(e);
  endtask

  task automatic wait_edge(input int tgt);
    while (ecnt < tgt) @(negedge GL0);
  endtask

  // Edge counter and scoreboard: compare each expectation 2 time units after its edge
  initial begin
    exp_t e;
    forever begin
      @(posedge GL0);
      ecnt++;
      #2;
      while (q.size() > 0 && q[0].cyc <= ecnt) begin
        e = q.pop_front();
        if (e.cyc < ecnt) begin
          check_val({e.tag, ".missed"}, 32'(ecnt), 32'(e.cyc));
        end else begin
          check_val({e.tag, ".state"}, 32'(STATE), 32'(e.st));
          check_val({e.tag, ".rst_n"}, 32'(FABRIC_RESET_N), 32'(e.rn));
          check_val({e.tag, ".run_start"}, 32'(RUN_START), 32'(e.rs));
          check_val({e.tag, ".lost_cnt"}, 32'(LOCK_LOST_CNT), 32'(e.lc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got edge %0d expected completion", ecnt);
    $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
    $finish;
  end

  initial begin
    int e0, t, u, r, w, h, run;
    RESET        = 1'b1;
    LOCK         = 1'b0;
    MSS_READY    = 1'b1;
    SW_RESET_REQ = 1'b0;
    repeat (3) @(negedge GL0);
    push_exp(ecnt + 1, "reset", 3'd0, 1'b0, 1'b0, 8'd0);
    @(negedge GL0);

    // Normal start: LOCK rises before edge e0+1
    RESET = 1'b0;
    e0 = ecnt + 1;
    push_exp(e0, "start_wl", 3'd1, 1'b0, 1'b0, 8'd0);
    @(negedge GL0);
    LOCK = 1'b1;
    run = e0 + 3 + LSC + MSS_EXTRA + RHC;
    push_exp(e0 + 2, "start_wl2", 3'd1, 1'b0, 1'b0, 8'd0);
    push_exp(e0 + 3, "start_stable", 3'd2, 1'b0, 1'b0, 8'd0);
    push_exp(e0 + 10, "start_stable_end", 3'd2, 1'b0, 1'b0, 8'd0);
    push_exp(e0 + 11, "start_after_stable", ST_AFTER_STABLE, 1'b0, 1'b0, 8'd0);
    push_exp(run - 1, "start_hold_end", 3'd4, 1'b0, 1'b0, 8'd0);
    push_exp(run, "start_run", 3'd5, 1'b1, 1'b1, 8'd0);
    push_exp(run + 1, "start_run2", 3'd5, 1'b1, 1'b0, 8'd0);
    wait_edge(run + 3);

    // Software request in RUN: reset low for exactly RHC cycles
    t = ecnt;
    SW_RESET_REQ = 1'b1;
    push_exp(t + 1, "sw_hold0", 3'd4, 1'b0, 1'b0, 8'd0);
    push_exp(t + 2, "sw_hold1", 3'd4, 1'b0, 1'b0, 8'd0);
    push_exp(t + 4, "sw_hold3", 3'd4, 1'b0, 1'b0, 8'd0);
    push_exp(t + 5, "sw_run", 3'd5, 1'b1, 1'b1, 8'd0);
    push_exp(t + 6, "sw_run2", 3'd5, 1'b1, 1'b0, 8'd0);
    @(negedge GL0);
    SW_RESET_REQ = 1'b0;
    wait_edge(t + 8);

    // Lock loss in RUN with a request on the cycle lock_s falls
    t = ecnt;
    LOCK = 1'b0;
    push_exp(t + 2, "ll_pre", 3'd5, 1'b1, 1'b0, 8'd0);
    push_exp(t + 3, "ll_drop", 3'd1, 1'b0, 1'b0, 8'd1);
    push_exp(t + 5, "ll_wait", 3'd1, 1'b0, 1'b0, 8'd1);
    wait_edge(t + 2);
    SW_RESET_REQ = 1'b1;
    @(negedge GL0);
    SW_RESET_REQ = 1'b0;
    wait_edge(t + 6);

    // Relock, then a 3-cycle glitch mid-STABLE restarts the full dwell
    u = ecnt;
    LOCK = 1'b1;
    r = u + 11 + LSC + MSS_EXTRA + RHC;
    push_exp(u + 3, "gl_stable", 3'd2, 1'b0, 1'b0, 8'd1);
    push_exp(u + 7, "gl_stable_late", 3'd2, 1'b0, 1'b0, 8'd1);
    wait_edge(u + 5);
    LOCK = 1'b0;
    push_exp(u + 8, "gl_drop", 3'd1, 1'b0, 1'b0, 8'd2);
    push_exp(u + 10, "gl_wl", 3'd1, 1'b0, 1'b0, 8'd2);
    push_exp(u + 11, "gl_restable", 3'd2, 1'b0, 1'b0, 8'd2);
    push_exp(u + 18, "gl_stable_end", 3'd2, 1'b0, 1'b0, 8'd2);
    push_exp(u + 19, "gl_after_stable", ST_AFTER_STABLE, 1'b0, 1'b0, 8'd2);
    push_exp(r - 1, "gl_hold_end", 3'd4, 1'b0, 1'b0, 8'd2);
    push_exp(r, "gl_run", 3'd5, 1'b1, 1'b1, 8'd2);
    wait_edge(u + 8);
    LOCK = 1'b1;
    wait_edge(r + 2);

    // 300 lock-loss events saturate the counter
    for (int i = 0; i < 300; i++) begin
      LOCK = 1'b0;
      repeat (3) @(negedge GL0);
      if (i < 299) begin
        LOCK = 1'b1;
        repeat (3) @(negedge GL0);
      end
    end
    w = ecnt;
    LOCK = 1'b1;
    h = w + 3 + LSC + MSS_EXTRA;
    push_exp(w + 3, "sat_stable", 3'd2, 1'b0, 1'b0, 8'hFF);
    push_exp(h, "sat_hold", 3'd4, 1'b0, 1'b0, 8'hFF);
    push_exp(h + 1, "sat_hold1", 3'd4, 1'b0, 1'b0, 8'hFF);
    push_exp(h + 2, "mid_reset", 3'd0, 1'b0, 1'b0, 8'd0);
    push_exp(h + 3, "post_reset", 3'd1, 1'b0, 1'b0, 8'd0);
    wait_edge(h + 1);
    RESET = 1'b1;
    @(negedge GL0);
    RESET = 1'b0;
    wait_edge(h + 5);

    check_val("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
